// File: rtl/bus_decoder.sv
// bus_decoder: routes one master to SLAVE_CNT slaves by base/mask address match.
// The decode result is registered in IDLE and held for the whole transaction.
// Unmapped addresses and slaves that never answer get an error response.
module bus_decoder #(
    parameter int                        SLAVE_CNT      = 2,
    parameter logic [32*SLAVE_CNT-1:0]   SLAVE_BASE     = {32'h10000000, 32'h00000000},
    parameter logic [32*SLAVE_CNT-1:0]   SLAVE_MASK     = {32'hF0000000, 32'hF0000000},
    parameter int                        TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            m_addr,
    input  logic [31:0]            m_wdata,
    input  logic [3:0]             m_wen,
    input  logic                   m_valid,
    output logic [31:0]            m_rdata,
    output logic                   m_ready,
    output logic                   m_err,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    output logic [3:0]             s_wen,
    output logic [SLAVE_CNT-1:0]   s_valid,
    input  logic [32*SLAVE_CNT-1:0] s_rdata,
    input  logic [SLAVE_CNT-1:0]   s_ready,
    output logic [31:0]            currslave
);

    // Index width of the slave select; kept at least one bit for SLAVE_CNT = 1.
    localparam int IW = (SLAVE_CNT > 1) ? $clog2(SLAVE_CNT) : 1;
    // Timeout counter width; a disabled timeout still needs a legal vector.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TLIM = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] sel;
    logic [CW-1:0] tcnt;
    logic [31:0]   rdata_q;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          sel_ready;
    logic [31:0]   sel_rdata;
    logic          timed_out;

    // Address decode: scan high to low so the lowest matching slave wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = SLAVE_CNT - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Only the latched slave's ready/data are looked at; the rest are ignored.
    assign sel_ready = s_ready[sel];
    assign sel_rdata = s_rdata[32*int'(sel) +: 32];
    assign timed_out = (TIMEOUT_CYCLES != 0) && (tcnt == TLIM);

    // Transaction sequencing: decode, wait for the slave, then hold the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            sel     <= '0;
            tcnt    <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (m_valid) begin
                        if (hit) begin
                            sel   <= hit_idx;
                            tcnt  <= '0;
                            state <= S_ACTIVE;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                end
                S_ACTIVE: begin
                    // A master abort takes priority; the slave never saw a valid beat.
                    if (!m_valid) begin
                        state <= S_IDLE;
                    end else if (sel_ready) begin
                        rdata_q <= sel_rdata;
                        state   <= S_DONE;
                    end else if (timed_out) begin
                        state <= S_ERR;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                default: begin
                    if (!m_valid) state <= S_IDLE;
                end
            endcase
        end
    end

    // Response and request steering; purely from state so reset drops them at once.
    always_comb begin
        s_valid = '0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_rdata = '0;
        case (state)
            S_ACTIVE: begin
                s_valid[sel] = m_valid;
                m_ready      = sel_ready;
                m_rdata      = sel_rdata;
            end
            S_DONE: begin
                m_ready = 1'b1;
                m_rdata = rdata_q;
            end
            S_ERR: begin
                m_ready = 1'b1;
                m_err   = 1'b1;
            end
            default: ;
        endcase
    end

    assign s_addr    = m_addr;
    assign s_wdata   = m_wdata;
    assign s_wen     = m_wen;
    assign currslave = 32'(sel);

endmodule

// File: tb/tb_bus_decoder.sv
// tb_bus_decoder: directed vectors against two decoder instances, one with the
// default address map and one with fully overlapping maps, both with an
// 8-cycle timeout. A transaction-level model checks every cycle; directed
// checks pin the cycle timing with hand-computed values.
module tb_bus_decoder;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wen;
    logic        m_valid;
    logic [63:0] s_rdata;
    logic [1:0]  s_ready;

    logic [31:0] o_rd   [2];
    logic        o_rdy  [2];
    logic        o_err  [2];
    logic [31:0] o_addr [2];
    logic [31:0] o_wd   [2];
    logic [3:0]  o_wen  [2];
    logic [1:0]  o_sv   [2];
    logic [31:0] o_cs   [2];

    int vectors;
    int miscompares;
    bit chk_en;

    bus_decoder #(.SLAVE_CNT(2), .TIMEOUT_CYCLES(TO)) u_a (
        .clk(clk), .reset(rst_n), .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen),
        .m_valid(m_valid), .m_rdata(o_rd[0]), .m_ready(o_rdy[0]), .m_err(o_err[0]),
        .s_addr(o_addr[0]), .s_wdata(o_wd[0]), .s_wen(o_wen[0]), .s_valid(o_sv[0]),
        .s_rdata(s_rdata), .s_ready(s_ready), .currslave(o_cs[0])
    );

    bus_decoder #(.SLAVE_CNT(2), .SLAVE_BASE(64'h0), .SLAVE_MASK(64'h0), .TIMEOUT_CYCLES(TO)) u_b (
        .clk(clk), .reset(rst_n), .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen),
        .m_valid(m_valid), .m_rdata(o_rd[1]), .m_ready(o_rdy[1]), .m_err(o_err[1]),
        .s_addr(o_addr[1]), .s_wdata(o_wd[1]), .s_wen(o_wen[1]), .s_valid(o_sv[1]),
        .s_rdata(s_rdata), .s_ready(s_ready), .currslave(o_cs[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Per instance: phase 0 idle, 1 waiting on slave, 2 answered, 3 error.
    int          ph     [2];
    int          tgt    [2];
    int          waited [2];
    logic [31:0] held   [2];

    function automatic int decode(int k, logic [31:0] a);
        logic [31:0] base [2];
        logic [31:0] mask [2];
        if (k == 0) begin
            base[0] = 32'h00000000; mask[0] = 32'hF0000000;
            base[1] = 32'h10000000; mask[1] = 32'hF0000000;
        end else begin
            base[0] = 32'h0; mask[0] = 32'h0;
            base[1] = 32'h0; mask[1] = 32'h0;
        end
        for (int i = 0; i < 2; i++)
            if ((a & mask[i]) == base[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                ph[k] <= 0; tgt[k] <= 0; waited[k] <= 0; held[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ph[k] == 0) begin
                    if (m_valid) begin
                        if (decode(k, m_addr) < 0) ph[k] <= 3;
                        else begin
                            tgt[k] <= decode(k, m_addr); waited[k] <= 0; ph[k] <= 1;
                        end
                    end
                end else if (ph[k] == 1) begin
                    if (!m_valid) ph[k] <= 0;
                    else if (s_ready[tgt[k]]) begin
                        held[k] <= s_rdata[32*tgt[k] +: 32]; ph[k] <= 2;
                    end else begin
                        waited[k] <= waited[k] + 1;
                        if (waited[k] + 1 == TO) ph[k] <= 3;
                    end
                end else if (!m_valid) begin
                    ph[k] <= 0;
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [1:0]  e_sv;
                logic        e_rdy;
                logic [31:0] e_rd;
                e_sv  = '0;
                e_rdy = 1'b0;
                e_rd  = '0;
                if (ph[k] == 1) begin
                    e_sv[tgt[k]] = m_valid;
                    e_rdy        = s_ready[tgt[k]];
                    e_rd         = s_rdata[32*tgt[k] +: 32];
                end else if (ph[k] == 2) begin
                    e_rdy = 1'b1;
                    e_rd  = held[k];
                end else if (ph[k] == 3) begin
                    e_rdy = 1'b1;
                end
                chk($sformatf("m%0d_s_valid", k), 32'(o_sv[k]), 32'(e_sv));
                chk($sformatf("m%0d_m_ready", k), 32'(o_rdy[k]), 32'(e_rdy));
                chk($sformatf("m%0d_currslave", k), o_cs[k], 32'(tgt[k]));
                chk($sformatf("m%0d_s_addr", k), o_addr[k], m_addr);
                if (e_rdy) begin
                    chk($sformatf("m%0d_m_err", k), 32'(o_err[k]), 32'(ph[k] == 3));
                    chk($sformatf("m%0d_m_rdata", k), o_rd[k], e_rd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        vectors = 0; miscompares = 0; chk_en = 1'b0;
        rst_n = 1'b0; m_addr = '0; m_wdata = '0; m_wen = '0; m_valid = 1'b0;
        s_rdata = '0; s_ready = '0;
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("rst_s_valid", 32'(o_sv[k]), 32'h0);
            chk("rst_m_ready", 32'(o_rdy[k]), 32'h0);
            chk("rst_m_err", 32'(o_err[k]), 32'h0);
            chk("rst_m_rdata", o_rd[k], 32'h0);
            chk("rst_currslave", o_cs[k], 32'h0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Read slave 1, combinational ready.
        m_addr = 32'h10000040; s_rdata = {32'hCAFEF00D, 32'h11112222}; s_ready = 2'b10; m_valid = 1'b1;
        tick(); @(negedge clk);
        chk("t1_c1_s_valid", 32'(o_sv[0]), 32'h2);
        chk("t1_c1_m_ready", 32'(o_rdy[0]), 32'h1);
        chk("t1_c1_m_rdata", o_rd[0], 32'hCAFEF00D);
        chk("t1_c1_m_err", 32'(o_err[0]), 32'h0);
        chk("t1_ovl_s_valid", 32'(o_sv[1]), 32'h1);
        tick();
        m_valid = 1'b0; s_rdata = {32'hDEADBEEF, 32'h0}; s_ready = 2'b00;
        @(negedge clk);
        chk("t1_c2_m_ready", 32'(o_rdy[0]), 32'h1);
        chk("t1_c2_m_rdata", o_rd[0], 32'hCAFEF00D);
        chk("t1_c2_s_valid", 32'(o_sv[0]), 32'h0);
        tick(); @(negedge clk);
        chk("t1_c3_m_ready", 32'(o_rdy[0]), 32'h0);
        chk("t1_c3_currslave", o_cs[0], 32'h1);
        tick();

        // Write slave 0, ready after 5 cycles.
        m_addr = 32'h00000008; m_wdata = 32'h12345678; m_wen = 4'b0011; s_ready = 2'b00; m_valid = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("t2_wait_s_valid", 32'(o_sv[0]), 32'h1);
            chk("t2_wait_m_ready", 32'(o_rdy[0]), 32'h0);
            tick();
        end
        s_ready = 2'b01;
        @(negedge clk);
        chk("t2_c6_m_ready", 32'(o_rdy[0]), 32'h1);
        chk("t2_s_wen", 32'(o_wen[0]), 32'h3);
        chk("t2_s_wdata", o_wd[0], 32'h12345678);
        tick();
        m_valid = 1'b0; s_ready = 2'b00; m_wen = 4'b0000;
        tick(); tick();

        // Unmapped address.
        m_addr = 32'hF0000000; s_rdata = {32'h55555555, 32'h66666666}; m_valid = 1'b1;
        tick(); @(negedge clk);
        chk("t3_m_ready", 32'(o_rdy[0]), 32'h1);
        chk("t3_m_err", 32'(o_err[0]), 32'h1);
        chk("t3_m_rdata", o_rd[0], 32'h0);
        chk("t3_s_valid", 32'(o_sv[0]), 32'h0);
        tick();
        m_valid = 1'b0;
        tick(); tick();

        // Timeout on slave 0, then a normal access to slave 1.
        m_addr = 32'h00000100; s_ready = 2'b00; m_valid = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("t4_wait_s_valid", 32'(o_sv[0]), 32'h1);
            chk("t4_wait_m_ready", 32'(o_rdy[0]), 32'h0);
            tick();
        end
        @(negedge clk);
        chk("t4_c9_s_valid", 32'(o_sv[0]), 32'h0);
        chk("t4_c9_m_ready", 32'(o_rdy[0]), 32'h1);
        chk("t4_c9_m_err", 32'(o_err[0]), 32'h1);
        tick();
        m_valid = 1'b0;
        tick(); tick();
        m_addr = 32'h10000004; s_rdata = {32'hA5A50001, 32'h0}; s_ready = 2'b10; m_valid = 1'b1;
        tick(); @(negedge clk);
        chk("t4_next_m_ready", 32'(o_rdy[0]), 32'h1);
        chk("t4_next_m_err", 32'(o_err[0]), 32'h0);
        chk("t4_next_m_rdata", o_rd[0], 32'hA5A50001);
        tick();
        m_valid = 1'b0; s_ready = 2'b00;
        tick(); tick();

        // Overlapping map: slave 0 wins; stray s_ready[1] is ignored.
        m_addr = 32'h10000010; s_rdata = {32'hBADBAD00, 32'h0}; s_ready = 2'b10; m_valid = 1'b1;
        tick();
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk("t5_stray_s_valid", 32'(o_sv[1]), 32'h1);
            chk("t5_stray_m_ready", 32'(o_rdy[1]), 32'h0);
            tick();
        end
        s_ready = 2'b01; s_rdata = {32'hBADBAD00, 32'h5A5A5A5A};
        @(negedge clk);
        chk("t5_m_ready", 32'(o_rdy[1]), 32'h1);
        chk("t5_m_rdata", o_rd[1], 32'h5A5A5A5A);
        chk("t5_currslave", o_cs[1], 32'h0);
        tick();
        m_valid = 1'b0; s_ready = 2'b00;
        tick(); tick();

        // Reset asserted while ACTIVE.
        m_addr = 32'h10000000; s_ready = 2'b00; m_valid = 1'b1;
        tick(); @(negedge clk);
        chk("t6_active_s_valid", 32'(o_sv[0]), 32'h2);
        chk("t6_active_currslave", o_cs[0], 32'h1);
        #1 s_ready = 2'b10;
        #1 chk("t6_pre_m_ready", 32'(o_rdy[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t6_rst_s_valid", 32'(o_sv[k]), 32'h0);
            chk("t6_rst_m_ready", 32'(o_rdy[k]), 32'h0);
            chk("t6_rst_currslave", o_cs[k], 32'h0);
        end
        m_valid = 1'b0; s_ready = 2'b00;
        #1 rst_n = 1'b1;
        tick(); @(negedge clk);
        chk("t6_post_m_ready", 32'(o_rdy[0]), 32'h0);
        chk("t6_post_s_valid", 32'(o_sv[0]), 32'h0);
        chk("t6_post_currslave", o_cs[0], 32'h0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
